// File: rtl/dbg_pkg.sv
// =============================================================================
// dbg_pkg: shared states, opcodes and reply words for the debugger command path
// Revision: 1.0
// =============================================================================
`default_nettype none

package dbg_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_GET_ADDR = 3'd1,
      S_GET_DATA = 3'd2,
      S_BUS      = 3'd3,
      S_RESP     = 3'd4
   } state_t;

   localparam logic [31:0] OP_READ  = 32'h0000_0001;
   localparam logic [31:0] OP_WRITE = 32'h0000_0002;
   localparam logic [31:0] OP_PING  = 32'h0000_0003;

   localparam logic [31:0] RESP_ACK = 32'h0000_00A5;
   localparam logic [31:0] RESP_NAK = 32'hFFFF_FFFF;

   // Inter-word gap in clocks: MHz * ms * 1000
   function automatic int timeout_cycles(input int clk_rate_mhz, input int gap_ms);
      return clk_rate_mhz * gap_ms * 1000;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dbg_cmd_parser_if.sv
// =============================================================================
// dbg_cmd_parser_if: UART word, memory bus and reply signals of the parser
// Revision: 1.0
// =============================================================================
`default_nettype none

interface dbg_cmd_parser_if;

   logic        rx_ready;
   logic [31:0] rx_word;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic        tx_busy;
   logic        tx_start;
   logic [31:0] tx_word;
   logic        drop;

   // Parser side: drives the memory request and the reply
   modport master (
      input  rx_ready, rx_word, bus_ack, bus_rdata, tx_busy,
      output bus_req, bus_we, bus_addr, bus_wdata, tx_start, tx_word, drop
   );

   // Environment side: UART receiver/transmitter and target memory
   modport slave (
      output rx_ready, rx_word, bus_ack, bus_rdata, tx_busy,
      input  bus_req, bus_we, bus_addr, bus_wdata, tx_start, tx_word, drop
   );

endinterface

`default_nettype wire

// File: rtl/dbg_timeout_cnt.sv
// =============================================================================
// dbg_timeout_cnt: inter-word gap counter, expires after LIMIT enabled clocks
// Revision: 1.0
// =============================================================================
`default_nettype none

module dbg_timeout_cnt #(
   parameter int LIMIT = 1000
) (
   input  wire logic clk,
   input  wire logic rst_n,
   input  wire logic clear,
   input  wire logic enable,
   output logic      expired
);

   localparam int W = $clog2(LIMIT + 1);

   logic [W-1:0] cnt;

   // A clear in the expiry cycle suppresses expiry so an arriving word wins
   assign expired = enable && !clear && (cnt == W'(LIMIT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear || !enable) begin
         cnt <= '0;
      end else if (!expired) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/dbg_cmd_parser.sv
// =============================================================================
// dbg_cmd_parser: assembles UART words into READ/WRITE/PING commands, runs them
// on the memory bus, returns one reply word. Option: DBG_CMD_TIMEOUT_EN.
// Revision: 1.0
// =============================================================================
`default_nettype none

module dbg_cmd_parser
   import dbg_pkg::*;
#(
   parameter int CLK_RATE     = -1,
   parameter int WORD_TIMEOUT = 500
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   dbg_cmd_parser_if.master dbg
);

   state_t      state;
   logic        bus_req_q;
   logic        bus_we_q;
   logic [31:0] bus_addr_q;
   logic [31:0] bus_wdata_q;
   logic [31:0] reply;
   logic [31:0] tx_word_q;
   logic        drop_q;
   logic        tx_fire;
   logic        timeout_expired;

`ifdef DBG_CMD_TIMEOUT_EN
   localparam int TIMEOUT_CYCLES = timeout_cycles(CLK_RATE, WORD_TIMEOUT);

   logic in_get;
   assign in_get = (state == S_GET_ADDR) || (state == S_GET_DATA);

   dbg_timeout_cnt #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (dbg.rx_ready),
      .enable  (in_get),
      .expired (timeout_expired)
   );
`else
   logic unused_cfg;
   assign unused_cfg      = ^{CLK_RATE[0], WORD_TIMEOUT[0]};
   assign timeout_expired = 1'b0;
`endif

   assign tx_fire = (state == S_RESP) && !dbg.tx_busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         reply       <= '0;
         tx_word_q   <= '0;
         drop_q      <= 1'b0;
      end else begin
         drop_q <= 1'b0;
         if (tx_fire) begin
            tx_word_q <= reply;
         end
         case (state)
            S_IDLE: begin
               if (dbg.rx_ready) begin
                  if ((dbg.rx_word == OP_READ) || (dbg.rx_word == OP_WRITE)) begin
                     bus_we_q <= (dbg.rx_word == OP_WRITE);
                     state    <= S_GET_ADDR;
                  end else if (dbg.rx_word == OP_PING) begin
                     reply <= RESP_ACK;
                     state <= S_RESP;
                  end else begin
                     reply <= RESP_NAK;
                     state <= S_RESP;
                  end
               end
            end
            S_GET_ADDR: begin
               if (dbg.rx_ready) begin
                  bus_addr_q <= dbg.rx_word;
                  if (bus_we_q) begin
                     state <= S_GET_DATA;
                  end else begin
                     bus_req_q <= 1'b1;
                     state     <= S_BUS;
                  end
               end else if (timeout_expired) begin
                  drop_q <= 1'b1;
                  state  <= S_IDLE;
               end
            end
            S_GET_DATA: begin
               if (dbg.rx_ready) begin
                  bus_wdata_q <= dbg.rx_word;
                  bus_req_q   <= 1'b1;
                  state       <= S_BUS;
               end else if (timeout_expired) begin
                  drop_q <= 1'b1;
                  state  <= S_IDLE;
               end
            end
            S_BUS: begin
               if (dbg.rx_ready) begin
                  drop_q <= 1'b1;
               end
               if (dbg.bus_ack) begin
                  bus_req_q <= 1'b0;
                  reply     <= bus_we_q ? RESP_ACK : dbg.bus_rdata;
                  state     <= S_RESP;
               end
            end
            S_RESP: begin
               if (dbg.rx_ready) begin
                  drop_q <= 1'b1;
               end
               if (!dbg.tx_busy) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign dbg.bus_req   = bus_req_q;
   assign dbg.bus_we    = bus_we_q;
   assign dbg.bus_addr  = bus_addr_q;
   assign dbg.bus_wdata = bus_wdata_q;
   assign dbg.tx_start  = tx_fire;
   // Present the new reply on the strobe cycle, hold it until the next strobe
   assign dbg.tx_word   = tx_fire ? reply : tx_word_q;
   assign dbg.drop      = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_dbg_cmd_parser.sv
// =============================================================================
// tb_dbg_cmd_parser: directed self-checking bench for dbg_cmd_parser
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_dbg_cmd_parser;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   dbg_cmd_parser_if ifc ();

   dbg_cmd_parser #(
      .CLK_RATE     (1),
      .WORD_TIMEOUT (1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .dbg   (ifc.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++; if (ifc.bus_req !== 1'b0) begin errors++; $display("FAIL reset_bus_req got %b exp 0", ifc.bus_req); end
      checks++; if (ifc.bus_we !== 1'b0) begin errors++; $display("FAIL reset_bus_we got %b exp 0", ifc.bus_we); end
      checks++; if (ifc.bus_addr !== 32'h0 || ifc.bus_wdata !== 32'h0) begin errors++; $display("FAIL reset_addr_data got %h/%h exp 0/0", ifc.bus_addr, ifc.bus_wdata); end
      checks++; if (ifc.tx_start !== 1'b0 || ifc.tx_word !== 32'h0) begin errors++; $display("FAIL reset_tx got %b/%h exp 0/0", ifc.tx_start, ifc.tx_word); end
      checks++; if (ifc.drop !== 1'b0) begin errors++; $display("FAIL reset_drop got %b exp 0", ifc.drop); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_ping();
      ifc.rx_ready = 1'b1; ifc.rx_word = 32'h0000_0003; ifc.tx_busy = 1'b0;
      @(negedge clk);
      checks++; if (ifc.tx_start !== 1'b0) begin errors++; $display("FAIL ping_early_start got %b exp 0", ifc.tx_start); end
      step();
      ifc.rx_ready = 1'b0;
      @(negedge clk);
      checks++; if (ifc.tx_start !== 1'b1) begin errors++; $display("FAIL ping_start got %b exp 1", ifc.tx_start); end
      checks++; if (ifc.tx_word !== 32'h0000_00A5) begin errors++; $display("FAIL ping_word got %h exp 000000a5", ifc.tx_word); end
      checks++; if (ifc.bus_req !== 1'b0) begin errors++; $display("FAIL ping_bus_req got %b exp 0", ifc.bus_req); end
      step();
      @(negedge clk);
      checks++; if (ifc.tx_start !== 1'b0 || ifc.tx_word !== 32'h0000_00A5) begin errors++; $display("FAIL ping_hold got %b/%h exp 0/000000a5", ifc.tx_start, ifc.tx_word); end
      step();
   endtask

   task automatic test_write();
      ifc.rx_ready = 1'b1; ifc.rx_word = 32'h0000_0002;
      step();
      ifc.rx_word = 32'h0000_0100;
      step();
      ifc.rx_word = 32'hDEAD_BEEF;
      @(negedge clk);
      checks++; if (ifc.bus_req !== 1'b0) begin errors++; $display("FAIL wr_req_early got %b exp 0", ifc.bus_req); end
      step();
      ifc.rx_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (ifc.bus_req !== 1'b1 || ifc.bus_we !== 1'b1 || ifc.bus_addr !== 32'h0000_0100 || ifc.bus_wdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL wr_stall%0d got req=%b we=%b a=%h d=%h exp 1/1/00000100/deadbeef", i, ifc.bus_req, ifc.bus_we, ifc.bus_addr, ifc.bus_wdata);
         end
         step();
      end
      ifc.bus_ack = 1'b1;
      @(negedge clk);
      checks++; if (ifc.bus_req !== 1'b1 || ifc.tx_start !== 1'b0) begin errors++; $display("FAIL wr_ack_cycle got req=%b start=%b exp 1/0", ifc.bus_req, ifc.tx_start); end
      step();
      ifc.bus_ack = 1'b0;
      @(negedge clk);
      checks++; if (ifc.bus_req !== 1'b0) begin errors++; $display("FAIL wr_req_fall got %b exp 0", ifc.bus_req); end
      checks++; if (ifc.tx_start !== 1'b1 || ifc.tx_word !== 32'h0000_00A5) begin errors++; $display("FAIL wr_reply got %b/%h exp 1/000000a5", ifc.tx_start, ifc.tx_word); end
      step();
   endtask

   task automatic test_read_busy();
      int starts;
      starts = 0;
      ifc.rx_ready = 1'b1; ifc.rx_word = 32'h0000_0001;
      step();
      ifc.rx_word = 32'h0000_0200;
      step();
      ifc.rx_ready = 1'b0; ifc.tx_busy = 1'b1;
      @(negedge clk);
      checks++; if (ifc.bus_req !== 1'b1 || ifc.bus_we !== 1'b0 || ifc.bus_addr !== 32'h0000_0200) begin errors++; $display("FAIL rd_req got req=%b we=%b a=%h exp 1/0/00000200", ifc.bus_req, ifc.bus_we, ifc.bus_addr); end
      step();
      ifc.bus_ack = 1'b1; ifc.bus_rdata = 32'h1234_5678;
      step();
      ifc.bus_ack = 1'b0; ifc.bus_rdata = 32'h0;
      @(negedge clk);
      checks++; if (ifc.tx_word !== 32'h0000_00A5) begin errors++; $display("FAIL rd_word_held got %h exp 000000a5", ifc.tx_word); end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (ifc.tx_start === 1'b1) starts++;
         step();
      end
      checks++; if (starts !== 0) begin errors++; $display("FAIL rd_busy_starts got %0d exp 0", starts); end
      ifc.tx_busy = 1'b0;
      @(negedge clk);
      checks++; if (ifc.tx_start !== 1'b1 || ifc.tx_word !== 32'h1234_5678) begin errors++; $display("FAIL rd_reply got %b/%h exp 1/12345678", ifc.tx_start, ifc.tx_word); end
      for (int i = 0; i < 5; i++) begin
         step();
         @(negedge clk);
         if (ifc.tx_start === 1'b1) starts++;
      end
      checks++; if (starts !== 0 || ifc.tx_word !== 32'h1234_5678) begin errors++; $display("FAIL rd_single_start got extra=%0d word=%h exp 0/12345678", starts, ifc.tx_word); end
      step();
   endtask

   task automatic test_unknown_drop();
      ifc.rx_ready = 1'b1; ifc.rx_word = 32'h0000_0007;
      step();
      ifc.rx_ready = 1'b0;
      @(negedge clk);
      checks++; if (ifc.tx_start !== 1'b1 || ifc.tx_word !== 32'hFFFF_FFFF) begin errors++; $display("FAIL nak_reply got %b/%h exp 1/ffffffff", ifc.tx_start, ifc.tx_word); end
      step();
      ifc.rx_ready = 1'b1; ifc.rx_word = 32'h0000_0001;
      step();
      ifc.rx_word = 32'h0000_0300;
      step();
      ifc.rx_word = 32'hAAAA_5555;
      @(negedge clk);
      checks++; if (ifc.bus_req !== 1'b1 || ifc.drop !== 1'b0) begin errors++; $display("FAIL drop_pre got req=%b drop=%b exp 1/0", ifc.bus_req, ifc.drop); end
      step();
      ifc.rx_ready = 1'b0;
      @(negedge clk);
      checks++; if (ifc.drop !== 1'b1 || ifc.bus_req !== 1'b1 || ifc.bus_addr !== 32'h0000_0300) begin errors++; $display("FAIL drop_pulse got drop=%b req=%b a=%h exp 1/1/00000300", ifc.drop, ifc.bus_req, ifc.bus_addr); end
      step();
      ifc.bus_ack = 1'b1; ifc.bus_rdata = 32'hCAFE_F00D;
      @(negedge clk);
      checks++; if (ifc.drop !== 1'b0) begin errors++; $display("FAIL drop_width got %b exp 0", ifc.drop); end
      step();
      ifc.bus_ack = 1'b0;
      @(negedge clk);
      checks++; if (ifc.tx_start !== 1'b1 || ifc.tx_word !== 32'hCAFE_F00D) begin errors++; $display("FAIL drop_reply got %b/%h exp 1/cafef00d", ifc.tx_start, ifc.tx_word); end
      step();
      ifc.bus_ack = 1'b1;
      step();
      ifc.bus_ack = 1'b0;
      @(negedge clk);
      checks++; if (ifc.bus_req !== 1'b0 || ifc.tx_start !== 1'b0) begin errors++; $display("FAIL stray_ack got req=%b start=%b exp 0/0", ifc.bus_req, ifc.tx_start); end
      step();
   endtask

`ifdef DBG_CMD_TIMEOUT_EN
   task automatic test_timeout();
      int drop_at;
      int starts;
      int drops;
      drop_at = -1; starts = 0; drops = 0;
      ifc.rx_ready = 1'b1; ifc.rx_word = 32'h0000_0002;
      step();
      ifc.rx_ready = 1'b0;
      for (int c = 1; c <= 1100 && drop_at < 0; c++) begin
         @(negedge clk);
         if (ifc.drop === 1'b1) drop_at = c;
         if (ifc.tx_start === 1'b1) starts++;
         step();
      end
      checks++; if (drop_at < 1000 || drop_at > 1002) begin errors++; $display("FAIL timeout_cycle got %0d exp 1000..1002", drop_at); end
      checks++; if (starts !== 0) begin errors++; $display("FAIL timeout_no_reply got %0d exp 0", starts); end
      ifc.rx_ready = 1'b1; ifc.rx_word = 32'h0000_0003;
      step();
      ifc.rx_ready = 1'b0;
      @(negedge clk);
      checks++; if (ifc.tx_start !== 1'b1 || ifc.tx_word !== 32'h0000_00A5) begin errors++; $display("FAIL timeout_ping got %b/%h exp 1/000000a5", ifc.tx_start, ifc.tx_word); end
      step();
      // Gaps of 900 clocks each must not expire because every word clears the count
      ifc.rx_ready = 1'b1; ifc.rx_word = 32'h0000_0002;
      step();
      ifc.rx_ready = 1'b0;
      for (int w = 0; w < 2; w++) begin
         for (int c = 0; c < 899; c++) begin
            @(negedge clk);
            if (ifc.drop === 1'b1) drops++;
            step();
         end
         ifc.rx_ready = 1'b1; ifc.rx_word = (w == 0) ? 32'h0000_0400 : 32'h5A5A_0001;
         step();
         ifc.rx_ready = 1'b0;
      end
      @(negedge clk);
      checks++; if (drops !== 0 || ifc.bus_req !== 1'b1 || ifc.bus_wdata !== 32'h5A5A_0001) begin errors++; $display("FAIL timeout_clear got drops=%0d req=%b d=%h exp 0/1/5a5a0001", drops, ifc.bus_req, ifc.bus_wdata); end
      ifc.bus_ack = 1'b1;
      step();
      ifc.bus_ack = 1'b0;
      step();
   endtask
`else
   task automatic test_no_timeout();
      int drops;
      drops = 0;
      ifc.rx_ready = 1'b1; ifc.rx_word = 32'h0000_0002;
      step();
      ifc.rx_ready = 1'b0;
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         if (ifc.drop === 1'b1) drops++;
         step();
      end
      ifc.rx_ready = 1'b1; ifc.rx_word = 32'h0000_0400;
      step();
      ifc.rx_word = 32'h5A5A_0001;
      step();
      ifc.rx_ready = 1'b0;
      @(negedge clk);
      checks++; if (drops !== 0 || ifc.bus_req !== 1'b1 || ifc.bus_addr !== 32'h0000_0400) begin errors++; $display("FAIL no_timeout got drops=%0d req=%b a=%h exp 0/1/00000400", drops, ifc.bus_req, ifc.bus_addr); end
      ifc.bus_ack = 1'b1;
      step();
      ifc.bus_ack = 1'b0;
      step();
   endtask
`endif

   task automatic test_reset_mid_bus();
      ifc.rx_ready = 1'b1; ifc.rx_word = 32'h0000_0001;
      step();
      ifc.rx_word = 32'h0000_0500;
      step();
      ifc.rx_ready = 1'b0;
      #1;
      checks++; if (ifc.bus_req !== 1'b1) begin errors++; $display("FAIL rst_pre_req got %b exp 1", ifc.bus_req); end
      #1;
      rst_n = 1'b0;
      #1;
      checks++; if (ifc.bus_req !== 1'b0 || ifc.bus_addr !== 32'h0) begin errors++; $display("FAIL rst_async got req=%b a=%h exp 0/00000000", ifc.bus_req, ifc.bus_addr); end
      checks++; if (ifc.tx_word !== 32'h0) begin errors++; $display("FAIL rst_tx_word got %h exp 00000000", ifc.tx_word); end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      ifc.rx_ready = 1'b1; ifc.rx_word = 32'h0000_0003;
      step();
      ifc.rx_ready = 1'b0;
      @(negedge clk);
      checks++; if (ifc.tx_start !== 1'b1 || ifc.tx_word !== 32'h0000_00A5 || ifc.bus_req !== 1'b0) begin errors++; $display("FAIL rst_ping got %b/%h req=%b exp 1/000000a5/0", ifc.tx_start, ifc.tx_word, ifc.bus_req); end
      step();
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      rst_n         = 1'b0;
      ifc.rx_ready  = 1'b0;
      ifc.rx_word   = 32'h0;
      ifc.bus_ack   = 1'b0;
      ifc.bus_rdata = 32'h0;
      ifc.tx_busy   = 1'b0;
      repeat (3) @(posedge clk);
      test_reset();
      test_ping();
      test_write();
      test_read_busy();
      test_unknown_drop();
`ifdef DBG_CMD_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      test_reset_mid_bus();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/dbg_cmd_parser.md
# dbg_cmd_parser

Command sequencer directly downstream of the 32-bit UART word receiver in the debugger datapath. Consumes one-shot received words, assembles them into debugger commands (opcode word, then address and data words), and executes each on the target memory bus through a valid/ack handshake. Returns exactly one reply word per command to the UART word transmitter.

## Interface
Parameters:
- CLK_RATE, -1, clk rate in MHz; must be overridden.
- WORD_TIMEOUT, 500, maximum gap between words of one command, in ms.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous, active-low.
- rx_ready  input  1  one-cycle strobe: rx_word valid.
- rx_word  input  32  received word, big-endian assembled.
- bus_req  output  1  memory request; held high until bus_ack.
- bus_we  output  1  1 = write, 0 = read; stable while bus_req.
- bus_addr  output  32  request address; stable while bus_req.
- bus_wdata  output  32  write data; stable while bus_req.
- bus_ack  input  1  one-cycle completion; bus_rdata valid in the same cycle for reads.
- bus_rdata  input  32  read data.
- tx_busy  input  1  transmitter busy; tx_start is ignored while high.
- tx_start  output  1  one-cycle strobe: send tx_word.
- tx_word  output  32  reply word; holds its value until the next tx_start.
- drop  output  1  one-cycle pulse when a received word is discarded.

## Operation
- Opcode is rx_word[31:0] compared in full:
  - 0x0000_0001 READ: takes 1 further word (addr).
  - 0x0000_0002 WRITE: takes 2 further words (addr, data).
  - 0x0000_0003 PING: takes 0 further words.
  - Any other value: unknown.
- States:
  - IDLE: on rx_ready, latch the opcode.
    - READ/WRITE -> GET_ADDR.
    - PING -> RESP with reply 0x0000_00A5.
    - Unknown -> RESP with reply NAK 0xFFFF_FFFF.
  - GET_ADDR: on rx_ready, latch bus_addr. READ -> BUS; WRITE -> GET_DATA.
  - GET_DATA: on rx_ready, latch bus_wdata -> BUS.
  - BUS: bus_req=1. On bus_ack -> RESP.
    - READ reply = bus_rdata captured on the ack cycle.
    - WRITE reply = ACK 0x0000_00A5.
  - RESP: when tx_busy=0, pulse tx_start with the reply -> IDLE.
- rx_ready in BUS or RESP: word discarded, drop pulses, state unchanged.
- Address and data are used verbatim; no alignment checks.
- Reset values: bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, tx_start=0, tx_word=0, drop=0, state IDLE.
- Reset asserted mid-command aborts immediately. A pending bus request is dropped with no ack wait.

## Timing
- Each rx_ready in a GET_* or IDLE state is consumed in that cycle; the state advances on the next edge.
- bus_req rises 1 cycle after the final command word's rx_ready.
- bus_req falls on the edge after bus_ack.
- tx_start asserts the first cycle in RESP with tx_busy=0. Minimum latency from bus_ack to tx_start is 1 cycle.
- PING/unknown: tx_start asserts 1 cycle after rx_ready when tx_busy=0.
- bus_ack while bus_req=0 is ignored.
- rx_ready in the same cycle as the timeout expiry: the word wins and the counter clears.

## Configuration
- DBG_CMD_TIMEOUT_EN defined:
  - A counter of CLK_RATE*WORD_TIMEOUT*1000 clks runs in GET_ADDR/GET_DATA.
  - It clears on every accepted word.
  - On expiry: return to IDLE, discard the partial command, send no reply, pulse drop.
- DBG_CMD_TIMEOUT_EN undefined: no counter; GET_* states wait indefinitely.

## Structure
- Shared package dbg_pkg holds:
  - the state enum;
  - opcode constants OP_READ, OP_WRITE, OP_PING;
  - reply constants RESP_ACK, RESP_NAK.
- The timeout is a natural sub-module, dbg_timeout_cnt: clear/enable in, expired out, width $clog2(limit+1).
- Everything else is one always_ff FSM plus output assigns.

## Test plan
- PING 0x0000_0003, tx_busy=0 -> tx_start 1 cycle later, tx_word=0x0000_00A5, no bus_req.
- WRITE, 0x0000_0100, 0xDEAD_BEEF -> bus_req with we=1, addr 0x100, wdata 0xDEADBEEF. Held through 3 stall cycles; after ack, reply 0x0000_00A5.
- READ 0x0000_0200, bus_rdata=0x1234_5678 on ack -> bus_req with we=0, then tx_word=0x1234_5678. Reply held while tx_busy=1 for 10 cycles, then a single tx_start.
- Opcode 0x0000_0007 -> reply 0xFFFF_FFFF. An extra word sent during BUS -> drop pulse, state unaffected.
- With DBG_CMD_TIMEOUT_EN, CLK_RATE=1, WORD_TIMEOUT=1:
  - WRITE then no words -> IDLE after 1000 clks, drop pulse, no tx_start.
  - A subsequent PING is answered normally.
- rst_n pulled low during BUS -> bus_req=0 asynchronously. After release, PING replies correctly.
